// File: rtl/soc_system_pcp_0_cpu_0_div_cell.sv
// Iterative radix-2 restoring divider for the PCP Nios II core, one quotient bit per clock.
// Optional SOC_SYSTEM_DIV_ZERO_TRAP_EN adds M_div_zero and a short-circuit path for divisor 0.
module soc_system_pcp_0_cpu_0_div_cell #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] M_div_src1,
    input  logic [DATA_W-1:0] M_div_src2,
    input  logic              M_div_signed,
    input  logic              M_div_start,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_quotient,
    output logic [DATA_W-1:0] M_div_remainder
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
    ,
    output logic              M_div_zero
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t            state;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic              signed_q;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] rem;
    logic              q_neg;
    logic              r_neg;
    logic [CNT_W-1:0]  cnt;
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
    logic              zero_q;
`endif

    logic              src1_neg;
    logic              src2_neg;
    logic [DATA_W-1:0] src1_abs;
    logic [DATA_W-1:0] src2_abs;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   rem_diff;

    always_comb begin
        src1_neg  = signed_q & src1_q[DATA_W-1];
        src2_neg  = signed_q & src2_q[DATA_W-1];
        src1_abs  = src1_neg ? -src1_q : src1_q;
        src2_abs  = src2_neg ? -src2_q : src2_q;
        // One extra bit keeps the shifted partial remainder from overflowing before the compare.
        rem_shift = {rem, dvd[DATA_W-1]};
        rem_diff  = rem_shift - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            src1_q          <= '0;
            src2_q          <= '0;
            signed_q        <= 1'b0;
            dvd             <= '0;
            dvs             <= '0;
            rem             <= '0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            cnt             <= '0;
            M_div_busy      <= 1'b0;
            M_div_done      <= 1'b0;
            M_div_quotient  <= '0;
            M_div_remainder <= '0;
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
            zero_q          <= 1'b0;
            M_div_zero      <= 1'b0;
`endif
        end else begin
            M_div_done <= 1'b0;
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
            M_div_zero <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (M_div_start) begin
                        src1_q     <= M_div_src1;
                        src2_q     <= M_div_src2;
                        signed_q   <= M_div_signed;
                        M_div_busy <= 1'b1;
                        state      <= PREP;
                    end
                end
                PREP: begin
                    dvd   <= src1_abs;
                    dvs   <= src2_abs;
                    q_neg <= src1_neg ^ src2_neg;
                    r_neg <= src1_neg;
                    rem   <= '0;
                    cnt   <= CNT_W'(DATA_W - 1);
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
                    zero_q <= (src2_q == '0);
                    state  <= (src2_q == '0) ? FIX : ITER;
`else
                    state <= ITER;
`endif
                end
                ITER: begin
                    if (!rem_diff[DATA_W]) begin
                        rem <= rem_diff[DATA_W-1:0];
                        dvd <= {dvd[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[DATA_W-1:0];
                        dvd <= {dvd[DATA_W-2:0], 1'b0};
                    end
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
                    if (zero_q) begin
                        M_div_quotient  <= '1;
                        M_div_remainder <= src1_q;
                        M_div_zero      <= 1'b1;
                    end else begin
                        M_div_quotient  <= q_neg ? -dvd : dvd;
                        M_div_remainder <= r_neg ? -rem : rem;
                    end
                    zero_q <= 1'b0;
`else
                    M_div_quotient  <= q_neg ? -dvd : dvd;
                    M_div_remainder <= r_neg ? -rem : rem;
`endif
                    M_div_done <= 1'b1;
                    M_div_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_system_pcp_0_cpu_0_div_cell.sv
// Directed self-checking bench for soc_system_pcp_0_cpu_0_div_cell (DATA_W=32).
// Honours SOC_SYSTEM_DIV_ZERO_TRAP_EN when defined for the build.
module tb_soc_system_pcp_0_cpu_0_div_cell;

    localparam int unsigned W = 32;
    localparam int FULL_LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         sgn;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rmd;
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
    logic         dzero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    soc_system_pcp_0_cpu_0_div_cell #(.DATA_W(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .M_div_src1      (src1),
        .M_div_src2      (src2),
        .M_div_signed    (sgn),
        .M_div_start     (start),
        .M_div_busy      (busy),
        .M_div_done      (done),
        .M_div_quotient  (quot),
        .M_div_remainder (rmd)
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
        ,
        .M_div_zero      (dzero)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        bit           glitch;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts one divide (accept edge = next posedge) and waits for done with a cycle budget.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit glitch, output logic [W-1:0] q, output logic [W-1:0] r,
                          output int lat, output bit busy_ok, output logic zf);
        @(negedge clk);
        src1 = a; src2 = b; sgn = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_ok = 1'b1; q = '0; r = '0; zf = 1'b0;
        while (lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (glitch && lat == 5) begin
                start = 1'b1; src1 = 32'hDEAD_BEEF; src2 = 32'h3; sgn = ~s;
            end else if (glitch && lat == 7) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) begin
                q = quot; r = rmd;
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
                zf = dzero;
`endif
                break;
            end
        end
        start = 1'b0;
    endtask

    logic [W-1:0] q, r;
    logic         zf;
    int           lat, exp_lat;
    bit           bok;
    bit           saw_done;

    initial begin
        vecs[0]  = '{32'd100,        32'd7,          1'b0, 1'b1, 32'd14,        32'd2};
        vecs[1]  = '{-32'sd100,      32'd7,          1'b1, 1'b0, 32'hFFFFFFF2,  32'hFFFFFFFE};
        vecs[2]  = '{32'd100,        -32'sd7,        1'b1, 1'b0, 32'hFFFFFFF2,  32'd2};
        vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 1'b0, 32'h80000000,  32'd0};
        vecs[4]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 1'b0, 32'hFFFFFFFF,  32'd0};
        vecs[5]  = '{32'd5,          32'd9,          1'b0, 1'b0, 32'd0,         32'd5};
        vecs[6]  = '{32'd123456,     32'd789,        1'b0, 1'b0, 32'd156,       32'd372};
        vecs[7]  = '{-32'sd100,      -32'sd7,        1'b1, 1'b0, 32'd14,        32'hFFFFFFFE};
        vecs[8]  = '{32'hFFFFFFFF,   32'h10,         1'b0, 1'b0, 32'h0FFFFFFF,  32'hF};
        vecs[9]  = '{32'd7,          -32'sd100,      1'b1, 1'b0, 32'd0,         32'd7};
        vecs[10] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 1'b0, 32'd1,         32'd0};
        vecs[11] = '{32'd7,          32'd0,          1'b0, 1'b0, 32'hFFFFFFFF,  32'd7};
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
        vecs[12] = '{-32'sd7,        32'd0,          1'b1, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFF9};
`else
        vecs[12] = '{-32'sd7,        32'd0,          1'b1, 1'b0, 32'h00000001,  32'hFFFFFFF9};
`endif
        vecs[13] = '{32'd8,          32'd2,          1'b0, 1'b0, 32'd4,         32'd0};

        reset = 1'b1; start = 1'b0; src1 = '0; src2 = '0; sgn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quot", quot, 32'd0);
        check("reset_rem",  rmd,  32'd0);
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
        check("reset_zero", {31'd0, dzero}, 32'd0);
`endif
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].glitch, q, r, lat, bok, zf);
`ifdef SOC_SYSTEM_DIV_ZERO_TRAP_EN
            exp_lat = (vecs[i].b == '0) ? 2 : FULL_LAT;
            check($sformatf("v%0d_zero", i), {31'd0, zf}, {31'd0, (vecs[i].b == '0)});
`else
            exp_lat = FULL_LAT;
`endif
            check($sformatf("v%0d_quot", i), q, vecs[i].exp_q);
            check($sformatf("v%0d_rem", i),  r, vecs[i].exp_r);
            check($sformatf("v%0d_lat", i),  lat, exp_lat);
            check($sformatf("v%0d_busy", i), {31'd0, bok}, 32'd1);
        end

        // Abort mid-divide: reset lands during iteration 10 of 123456/789.
        @(negedge clk);
        src1 = 32'd123456; src2 = 32'd789; sgn = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quot", quot, 32'd0);
        check("abort_rem",  rmd,  32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        do_div(32'd123456, 32'd789, 1'b0, 1'b0, q, r, lat, bok, zf);
        check("post_abort_quot", q, 32'd156);
        check("post_abort_rem",  r, 32'd372);
        check("post_abort_lat",  lat, FULL_LAT);

        // Outputs hold after done while idle.
        repeat (3) @(posedge clk);
        #1;
        check("hold_quot", quot, 32'd156);
        check("hold_done", {31'd0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
